// File: rtl/dds_servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_servo_pkg
// Description : Shared types and helpers for the DDS frequency servo.
//               - servo_state_t : IDLE / MEASURE / UPDATE
//               - c_inc_reset   : default increment after reset (20 MHz @ 100 MHz)
//               - sat_count     : saturating +1 for tick counters (width <= 32)
//               - clamp_inc     : clamp a signed 64-bit sum into [lo, hi]
// Revision    : 1.0  initial release
// ============================================================================
package dds_servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_UPDATE  = 2'd2
    } servo_state_t;

    localparam logic [31:0] c_inc_reset = 32'h3333_3333;

    typedef struct packed {
        logic [31:0] value;
        logic        clamped;
    } clamp_t;

    // Counters narrower than 32 bits are passed zero-extended along with
    // their own all-ones ceiling, so one helper serves any width.
    function automatic logic [31:0] sat_count(input logic [31:0] cnt,
                                              input logic        tick,
                                              input logic [31:0] max_val);
        if (tick && (cnt < max_val))
            return cnt + 32'd1;
        return cnt;
    endfunction

    // Bounds are unsigned 32-bit values, so they are zero-extended before
    // the signed compare. An inverted range (lo > hi) resolves to hi.
    function automatic clamp_t clamp_inc(input logic signed [63:0] sum,
                                         input logic        [31:0] lo,
                                         input logic        [31:0] hi);
        clamp_t r;
        r.value   = sum[31:0];
        r.clamped = 1'b0;
        if (lo > hi) begin
            r.value   = hi;
            r.clamped = 1'b1;
        end else if (sum > $signed({32'd0, hi})) begin
            r.value   = hi;
            r.clamped = 1'b1;
        end else if (sum < $signed({32'd0, lo})) begin
            r.value   = lo;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_acc
// Description : Replica 32-bit phase accumulator. Adds the current DDS
//               increment every cycle; the carry out of that add is the local
//               tick used for frequency comparison.
// Ports       : clk_ref    - clock
//               rst_n      - asynchronous active-low reset
//               load       - clears the accumulator
//               increment  - phase step per cycle
//               local_tick - carry out of this cycle's add (combinational)
//               dds_msb    - accumulator bit 31 (registered)
// Revision    : 1.0  initial release
// ============================================================================
module dds_phase_acc (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] increment,
    output logic        local_tick,
    output logic        dds_msb
);

    logic [31:0] r_acc;
    logic [32:0] w_sum;

    assign w_sum      = {1'b0, r_acc} + {1'b0, increment};
    assign local_tick = w_sum[32];
    assign dds_msb    = r_acc[31];

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (load)
            r_acc <= '0;
        else
            r_acc <= w_sum[31:0];
    end

endmodule
`default_nettype wire

// File: rtl/dds_freq_servo.sv
`default_nettype none
// ============================================================================
// Module      : dds_freq_servo
// Description : Closed-loop DDS frequency servo. Counts reference ticks and
//               replica-accumulator overflows over a gate window, then steers
//               the DDS increment by (error <<< gain_shift), clamped to
//               [inc_min, inc_max]. Tracks lock over consecutive windows.
// Ports       : clk_ref, clk_ref_aresetn     - clock, async active-low reset
//               enable                       - run servo (low parks in IDLE)
//               load, inc_init               - force increment, clear phase
//               ext_tick                     - synchronized reference pulse
//               gate_cycles, gain_shift      - window length, loop gain
//               inc_min, inc_max             - unsigned clamp bounds
//               increment, dds_msb           - DDS step, replica MSB
//               update_strobe, last_error    - update pulse, window error
//               saturated, locked            - clamp flag, lock indicator
// Revision    : 1.0  initial release
// ============================================================================
module dds_freq_servo
    import dds_servo_pkg::*;
#(
    parameter logic [31:0] INC_RESET  = c_inc_reset,
    parameter int          CNT_W      = 24,
    parameter int          LOCK_TOL   = 2,
    parameter int          LOCK_COUNT = 4
) (
    input  logic              clk_ref,
    input  logic              clk_ref_aresetn,
    input  logic              enable,
    input  logic              load,
    input  logic              ext_tick,
    input  logic [31:0]       gate_cycles,
    input  logic [4:0]        gain_shift,
    input  logic [31:0]       inc_init,
    input  logic [31:0]       inc_min,
    input  logic [31:0]       inc_max,
    output logic [31:0]       increment,
    output logic              dds_msb,
    output logic              update_strobe,
    output logic [CNT_W:0]    last_error,
    output logic              saturated,
    output logic              locked
);

    localparam int                RUN_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0]  c_run_max = RUN_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic signed [CNT_W:0] c_tol = (CNT_W + 1)'(LOCK_TOL);

    servo_state_t        r_state;
    logic [31:0]         r_gate_cnt;
    logic [CNT_W-1:0]    r_ext_cnt;
    logic [CNT_W-1:0]    r_loc_cnt;
    logic [RUN_W-1:0]    r_run;
    logic [31:0]         r_increment;
    logic                r_update_strobe;
    logic [CNT_W:0]      r_last_error;
    logic                r_saturated;
    logic                r_locked;

    logic                w_local_tick;
    logic [31:0]         w_gate_init;
    logic signed [CNT_W:0] w_error;
    logic signed [63:0]  w_err_ext;
    logic signed [63:0]  w_delta;
    logic signed [63:0]  w_sum;
    clamp_t              w_clamp;
    logic                w_in_tol;
    logic [RUN_W-1:0]    w_run_next;
    logic [CNT_W-1:0]    w_ext_next;
    logic [CNT_W-1:0]    w_loc_next;

    dds_phase_acc u_phase_acc (
        .clk_ref    (clk_ref),
        .rst_n      (clk_ref_aresetn),
        .load       (load),
        .increment  (r_increment),
        .local_tick (w_local_tick),
        .dds_msb    (dds_msb)
    );

    // A zero-length gate is treated as one cycle.
    assign w_gate_init = (gate_cycles == 32'd0) ? 32'd0 : gate_cycles - 32'd1;

    assign w_ext_next = CNT_W'(sat_count(32'(r_ext_cnt), ext_tick,     32'(c_cnt_max)));
    assign w_loc_next = CNT_W'(sat_count(32'(r_loc_cnt), w_local_tick, 32'(c_cnt_max)));

    // Error arithmetic: counts are unsigned, so a leading zero makes the
    // CNT_W+1 signed difference exact. The 64-bit sum cannot overflow even
    // at maximum error and shift.
    assign w_error   = $signed({1'b0, r_ext_cnt}) - $signed({1'b0, r_loc_cnt});
    assign w_err_ext = 64'(w_error);
    assign w_delta   = w_err_ext <<< gain_shift;
    assign w_sum     = $signed({32'd0, r_increment}) + w_delta;
    assign w_clamp   = clamp_inc(w_sum, inc_min, inc_max);

    assign w_in_tol   = (w_error <= c_tol) && (w_error >= -c_tol);
    assign w_run_next = (r_run < c_run_max) ? r_run + 1'b1 : c_run_max;

    always_ff @(posedge clk_ref or negedge clk_ref_aresetn) begin
        if (!clk_ref_aresetn) begin
            r_state         <= ST_IDLE;
            r_gate_cnt      <= '0;
            r_ext_cnt       <= '0;
            r_loc_cnt       <= '0;
            r_run           <= '0;
            r_increment     <= INC_RESET;
            r_update_strobe <= 1'b0;
            r_last_error    <= '0;
            r_saturated     <= 1'b0;
            r_locked        <= 1'b0;
        end else begin
            r_update_strobe <= 1'b0;

            // load always overrides the servo result; any UPDATE in the same
            // cycle below skips its increment write.
            if (load)
                r_increment <= inc_init;

            if (!enable) begin
                // Park with counters armed so the next enable starts a clean
                // window; increment is left where it was.
                r_state    <= ST_IDLE;
                r_locked   <= 1'b0;
                r_run      <= '0;
                r_ext_cnt  <= '0;
                r_loc_cnt  <= '0;
                r_gate_cnt <= w_gate_init;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_MEASURE;
                        r_ext_cnt  <= '0;
                        r_loc_cnt  <= '0;
                        r_gate_cnt <= w_gate_init;
                    end

                    ST_MEASURE: begin
                        if (load) begin
                            r_ext_cnt  <= '0;
                            r_loc_cnt  <= '0;
                            r_gate_cnt <= w_gate_init;
                            r_locked   <= 1'b0;
                            r_run      <= '0;
                        end else begin
                            r_ext_cnt <= w_ext_next;
                            r_loc_cnt <= w_loc_next;
                            if (r_gate_cnt == 32'd0)
                                r_state <= ST_UPDATE;
                            else
                                r_gate_cnt <= r_gate_cnt - 32'd1;
                        end
                    end

                    ST_UPDATE: begin
                        r_state    <= ST_MEASURE;
                        r_ext_cnt  <= '0;
                        r_loc_cnt  <= '0;
                        r_gate_cnt <= w_gate_init;
                        if (load) begin
                            r_locked <= 1'b0;
                            r_run    <= '0;
                        end else begin
                            r_increment     <= w_clamp.value;
                            r_last_error    <= w_error;
                            r_saturated     <= w_clamp.clamped;
                            r_update_strobe <= 1'b1;
                            // A clamped window never counts toward lock.
                            if (w_in_tol && !w_clamp.clamped) begin
                                r_run    <= w_run_next;
                                r_locked <= (w_run_next >= c_run_max);
                            end else begin
                                r_run    <= '0;
                                r_locked <= 1'b0;
                            end
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign increment     = r_increment;
    assign update_strobe = r_update_strobe;
    assign last_error    = r_last_error;
    assign saturated     = r_saturated;
    assign locked        = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_dds_freq_servo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dds_freq_servo
// Description : Self-checking bench for dds_freq_servo. Scenario table plus
//               hand-written sequences; expected updates are queued when a
//               scenario starts and compared as update_strobe pulses arrive.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dds_freq_servo;

    localparam int CNT_W = 24;

    logic              clk_ref;
    logic              clk_ref_aresetn;
    logic              enable;
    logic              load;
    logic              ext_tick;
    logic [31:0]       gate_cycles;
    logic [4:0]        gain_shift;
    logic [31:0]       inc_init;
    logic [31:0]       inc_min;
    logic [31:0]       inc_max;
    logic [31:0]       increment;
    logic              dds_msb;
    logic              update_strobe;
    logic [CNT_W:0]    last_error;
    logic              saturated;
    logic              locked;

    dds_freq_servo dut (
        .clk_ref         (clk_ref),
        .clk_ref_aresetn (clk_ref_aresetn),
        .enable          (enable),
        .load            (load),
        .ext_tick        (ext_tick),
        .gate_cycles     (gate_cycles),
        .gain_shift      (gain_shift),
        .inc_init        (inc_init),
        .inc_min         (inc_min),
        .inc_max         (inc_max),
        .increment       (increment),
        .dds_msb         (dds_msb),
        .update_strobe   (update_strobe),
        .last_error      (last_error),
        .saturated       (saturated),
        .locked          (locked)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    typedef struct {
        logic signed [63:0] err;
        logic        [31:0] inc;
        logic               sat;
        logic               lck;
    } exp_t;

    typedef struct {
        int          period;
        logic [31:0] inc_max;
        int          n_upd;
        int          err;
        logic [31:0] inc;
        logic        sat;
    } vec_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    exp_t  e;
    vec_t  vecs[3];
    int    errors;
    int    checks;
    int    strobe_cnt;
    bit    sb_on;
    int    tick_period;
    int    tick_phase;
    int    got, k, s0, run, msb_hi, abs_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    task automatic do_reset();
        clk_ref_aresetn = 1'b0;
        enable          = 1'b0;
        load            = 1'b0;
        tick_period     = 0;
        sb_on           = 1'b0;
        step(3);
        clk_ref_aresetn = 1'b1;
        step(1);
    endtask

    task automatic pulse_load(input logic [31:0] val);
        inc_init = val;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, output int seen);
        int start;
        start = strobe_cnt;
        for (int i = 0; i < budget; i++) begin
            if (strobe_cnt - start >= n) break;
            step(1);
        end
        seen = strobe_cnt - start;
    endtask

    // Reference tick generator
    initial begin
        ext_tick   = 1'b0;
        tick_phase = 0;
        forever begin
            @(posedge clk_ref);
            #1;
            if (tick_period > 0) begin
                ext_tick = ((tick_phase % tick_period) == 0);
                tick_phase++;
            end else begin
                ext_tick = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every update pulse is checked against the queue
    initial begin
        strobe_cnt = 0;
        forever begin
            @(negedge clk_ref);
            if (update_strobe === 1'b1) begin
                strobe_cnt++;
                if (sb_on) begin
                    check("strobe_was_expected", 64'(sb_q.size() > 0), 64'd1);
                    if (sb_q.size() > 0) begin
                        mon_e = sb_q.pop_front();
                        check("sb_last_error", 64'($signed(last_error)), mon_e.err);
                        check("sb_increment",  64'(increment), 64'(mon_e.inc));
                        check("sb_saturated",  64'(saturated), 64'(mon_e.sat));
                        check("sb_locked",     64'(locked),    64'(mon_e.lck));
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors      = 0;
        checks      = 0;
        sb_on       = 1'b0;
        tick_period = 0;
        gate_cycles = 32'd1000;
        gain_shift  = 5'd20;
        inc_init    = 32'h4000_0000;
        inc_min     = 32'h0;
        inc_max     = 32'hFFFF_FFFF;

        vecs[0] = '{4, 32'hFFFF_FFFF, 5,   0, 32'h4000_0000, 1'b0};  // zero error
        vecs[1] = '{5, 32'hFFFF_FFFF, 1, -50, 32'h3CE0_0000, 1'b0};  // slow reference
        vecs[2] = '{2, 32'h4000_0000, 3, 250, 32'h4000_0000, 1'b1};  // clamp

        // ---- reset state and idle behaviour ----
        clk_ref_aresetn = 1'b0;
        enable          = 1'b0;
        load            = 1'b0;
        step(3);
        check("rst_increment",  64'(increment),     64'h3333_3333);
        check("rst_strobe",     64'(update_strobe), 64'd0);
        check("rst_last_error", 64'(last_error),    64'd0);
        check("rst_saturated",  64'(saturated),     64'd0);
        check("rst_locked",     64'(locked),        64'd0);
        check("rst_dds_msb",    64'(dds_msb),       64'd0);
        clk_ref_aresetn = 1'b1;
        s0 = strobe_cnt;
        step(1000);
        check("idle_no_strobe", 64'(strobe_cnt - s0), 64'd0);
        check("idle_increment", 64'(increment),       64'h3333_3333);
        check("idle_locked",    64'(locked),          64'd0);

        pulse_load(32'h4000_0000);
        check("load_idle_increment", 64'(increment), 64'h4000_0000);
        msb_hi = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (dds_msb) msb_hi++;
        end
        check("dds_msb_duty", 64'(msb_hi), 64'd4);

        // ---- table-driven scenarios ----
        for (int v = 0; v < 3; v++) begin
            do_reset();
            gate_cycles = 32'd1000;
            gain_shift  = 5'd20;
            inc_min     = 32'h0;
            inc_max     = vecs[v].inc_max;
            pulse_load(32'h4000_0000);
            run = 0;
            for (int u = 0; u < vecs[v].n_upd; u++) begin
                abs_err = (vecs[v].err < 0) ? -vecs[v].err : vecs[v].err;
                if (!vecs[v].sat && abs_err <= 2) run = (run < 4) ? run + 1 : 4;
                else run = 0;
                e.err = 64'(vecs[v].err);
                e.inc = vecs[v].inc;
                e.sat = vecs[v].sat;
                e.lck = (run >= 4);
                sb_q.push_back(e);
            end
            tick_period = vecs[v].period;
            sb_on       = 1'b1;
            enable      = 1'b1;
            wait_strobes(vecs[v].n_upd, vecs[v].n_upd * 1001 + 20, got);
            check("scenario_updates", 64'(got), 64'(vecs[v].n_upd));

            if (v == 0) begin
                // mid-window disable after lock was earned
                check("locked_after_run", 64'(locked), 64'd1);
                step(300);
                enable = 1'b0;
                step(2);
                check("disable_locked",    64'(locked),    64'd0);
                check("disable_increment", 64'(increment), 64'h4000_0000);
                s0 = strobe_cnt;
                step(1500);
                check("disable_no_strobe", 64'(strobe_cnt - s0), 64'd0);
                check("disable_inc_held",  64'(increment),       64'h4000_0000);
                // re-enable: fresh window, strobe gate_cycles+1 edges later
                e.err = 64'sd0; e.inc = 32'h4000_0000; e.sat = 1'b0; e.lck = 1'b0;
                sb_q.push_back(e);
                enable = 1'b1;
                step(1);
                k = 0;
                for (int i = 1; i <= 1200; i++) begin
                    step(1);
                    if (update_strobe) begin k = i; break; end
                end
                check("reenable_window_len", 64'(k), 64'd1001);
            end

            enable = 1'b0;
            step(2);
            check("sb_drained", 64'(sb_q.size()), 64'd0);
        end

        // ---- load coincident with UPDATE ----
        do_reset();
        gate_cycles = 32'd1000;
        gain_shift  = 5'd20;
        inc_min     = 32'h0;
        inc_max     = 32'hFFFF_FFFF;
        pulse_load(32'h4000_0000);
        tick_period = 5;
        enable      = 1'b1;
        step(1);
        step(1000);
        check("pre_update_increment", 64'(increment), 64'h4000_0000);
        inc_init = 32'h2000_0000;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
        check("load_beats_update", 64'(increment), 64'h2000_0000);
        k = 0;
        for (int i = 1; i <= 1200; i++) begin
            step(1);
            if (update_strobe) begin k = i; break; end
        end
        check("restart_window_len",  64'(k), 64'd1001);
        check("restart_last_error",  64'($signed(last_error)), 64'd75);
        check("restart_increment",   64'(increment), 64'h24B0_0000);
        check("restart_saturated",   64'(saturated), 64'd0);
        enable = 1'b0;

        // ---- gate_cycles = 0 behaves as 1 ----
        do_reset();
        gate_cycles = 32'd0;
        gain_shift  = 5'd0;
        inc_min     = 32'h0;
        inc_max     = 32'hFFFF_FFFF;
        pulse_load(32'h4000_0000);
        enable = 1'b1;
        step(1);
        for (int n = 0; n < 4; n++) begin
            k = 0;
            for (int i = 1; i <= 10; i++) begin
                step(1);
                if (update_strobe) begin k = i; break; end
            end
            check("gate0_interval", 64'(k), 64'd2);
        end
        enable = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
